// File: rtl/vld_ram_pkg.sv
// Shared definitions for the vld_dp_ram arbiter slice.
// Holds the arbiter state encoding and the index-width helper used to
// size requester indices; IDX_W is the width for the default NUM_REQ of 4.
package vld_ram_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int IDX_W           = idx_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/vld_ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_we/req_lock     : per-requester write flag and grant-hold request
//   req_addr/req_wdata  : packed per-requester address and write data
//   rsp_valid/rsp_data  : one-hot read-response strobe and shared read data
// master = client engines, slave = arbiter.
interface vld_ram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/vld_ram_arbiter_rr_pick.sv
// rr_pick: combinational first-set search over req starting at ptr and
// wrapping past N-1 back to 0.
//   req   : request vector
//   ptr   : search start index (must be < N)
//   idx   : index of the first set bit found
//   found : 1 when any bit of req is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  int unsigned j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/vld_ram_arbiter.sv
// vld_ram_arbiter: round-robin sharing of vld_dp_ram port A between
// NUM_REQ requesters, with locked bursts capped at MAX_HOLD beats.
//   clk, rst_n        : single clock, async active-low reset
//   bus (slave)       : requester handshake and read responses
//   ram_wr_en, ram_addr_vld, ram_addr, ram_din : registered RAM port A drive
//   ram_dout_vld, ram_dout                      : RAM port A read return
//   err_vld_mismatch  : sticky flag, RAM valid disagrees with expected read
module vld_ram_arbiter
  import vld_ram_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vld_ram_arbiter_if.slave      bus,
  output logic                  ram_wr_en,
  output logic                  ram_addr_vld,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic                  ram_dout_vld,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  err_vld_mismatch
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [IW-1:0]     pick_idx, acc_idx;
  logic              pick_found, acc;
  logic [NUM_REQ-1:0] ready, rsp;
  logic              rd_pend_q1, rd_pend_q2;
  logic [IW-1:0]     tag_q1, tag_q2;
  logic [1:0]        settle_q;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    ready    = '0;
    acc      = 1'b0;
    acc_idx  = pick_idx;
    case (state_q)
      ARB: begin
        if (pick_found) begin
          ready[pick_idx] = 1'b1;
          acc             = 1'b1;
          if (bus.req_lock[pick_idx] && (MAX_HOLD > 1)) begin
            state_d = HOLD;
            owner_d = pick_idx;
            hold_d  = HW'(1);
          end else begin
            rr_ptr_d = next_ptr(pick_idx);
          end
        end
      end
      HOLD: begin
        acc_idx = owner_q;
        // Owner dropping valid ends the burst with an idle bus cycle.
        if (bus.req_valid[owner_q]) begin
          ready[owner_q] = 1'b1;
          acc            = 1'b1;
          if (bus.req_lock[owner_q] && (int'(hold_q) + 1 < MAX_HOLD)) begin
            hold_d = hold_q + 1'b1;
          end else begin
            state_d  = ARB;
            rr_ptr_d = next_ptr(owner_q);
            hold_d   = '0;
          end
        end else begin
          state_d  = ARB;
          rr_ptr_d = next_ptr(owner_q);
          hold_d   = '0;
        end
      end
    endcase
  end

  assign bus.req_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ARB;
      rr_ptr_q         <= '0;
      owner_q          <= '0;
      hold_q           <= '0;
      ram_wr_en        <= 1'b0;
      ram_addr_vld     <= 1'b0;
      ram_addr         <= '0;
      ram_din          <= '0;
      rd_pend_q1       <= 1'b0;
      rd_pend_q2       <= 1'b0;
      tag_q1           <= '0;
      tag_q2           <= '0;
      settle_q         <= '0;
      err_vld_mismatch <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      hold_q       <= hold_d;
      ram_addr_vld <= acc;
      ram_wr_en    <= acc & bus.req_we[acc_idx];
      if (acc) begin
        ram_addr <= bus.req_addr[int'(acc_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_din  <= bus.req_wdata[int'(acc_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
      rd_pend_q1 <= acc & ~bus.req_we[acc_idx];
      tag_q1     <= acc_idx;
      rd_pend_q2 <= rd_pend_q1;
      tag_q2     <= tag_q1;
      // The RAM is not reset with us; its valid may be stale for two cycles.
      settle_q   <= {settle_q[0], 1'b1};
      if (settle_q[1] && !ram_wr_en && (rd_pend_q2 != ram_dout_vld))
        err_vld_mismatch <= 1'b1;
    end
  end

  always_comb begin
    rsp = '0;
    if (rd_pend_q2) rsp[tag_q2] = 1'b1;
  end

  assign bus.rsp_valid = rsp;
  assign bus.rsp_data  = ram_dout;

endmodule

// File: tb/tb_vld_ram_arbiter.sv
module tb_vld_ram_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vld_ram_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  logic          ram_wr_en, ram_addr_vld, ram_dout_vld, err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  vld_ram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .ram_wr_en        (ram_wr_en),
    .ram_addr_vld     (ram_addr_vld),
    .ram_addr         (ram_addr),
    .ram_din          (ram_din),
    .ram_dout_vld     (ram_dout_vld),
    .ram_dout         (ram_dout),
    .err_vld_mismatch (err)
  );

  // Write-first RAM port, never reset; dout_vld only follows reads.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          model_vld;
  logic          force_vld = 1'b0;
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
    model_vld <= 1'b0;
    ram_dout  <= '0;
  end
  always @(posedge clk) begin
    if (ram_addr_vld && ram_wr_en) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else if (ram_addr_vld) begin
      ram_dout <= mem[ram_addr];
    end
    model_vld <= ram_addr_vld & ~ram_wr_en;
  end
  assign ram_dout_vld = model_vld | force_vld;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (!ok) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] din; } iss_t;
  typedef struct { int cyc; int tag; logic [DW-1:0] data; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  // Reference: spec-level arbitration state and a flat memory image.
  logic [DW-1:0] refmem [0:(1<<AW)-1];
  int m_ptr = 0, m_owner = -1, m_beats = 0;
  logic exp_err = 1'b0;

  logic [N-1:0]  s_valid = '0, s_we = '0, s_lock = '0;
  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_wdata [N];
  int last_grant;

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_beats = 0;
    iss_q.delete(); rsp_q.delete();
  endtask

  task automatic step();
    int g;
    logic [N-1:0] exp_ready;
    @(posedge clk); #1;
    bus.req_valid = s_valid;
    bus.req_we    = s_we;
    bus.req_lock  = s_lock;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = s_addr[i];
      bus.req_wdata[i*DW +: DW] = s_wdata[i];
    end
    g = -1;
    if (m_owner >= 0) begin
      if (s_valid[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && s_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    exp_ready = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      iss_q.push_back('{cyc + 1, s_we[g], s_addr[g], s_wdata[g]});
      if (s_we[g]) refmem[s_addr[g]] = s_wdata[g];
      else rsp_q.push_back('{cyc + 2, g, refmem[s_addr[g]]});
    end
    if (m_owner >= 0) begin
      if (g < 0) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end else begin
        m_beats++;
        if (!s_lock[g] || m_beats >= MH) begin
          m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
      end
    end else if (g >= 0) begin
      if (s_lock[g] && MH > 1) begin
        m_owner = g; m_beats = 1;
      end else begin
        m_ptr = (g + 1) % N;
      end
    end
    #1;
    chk("req_ready", bus.req_ready === exp_ready, 64'(bus.req_ready), 64'(exp_ready));
    last_grant = -1;
    for (int i = N - 1; i >= 0; i--) if (bus.req_ready[i]) last_grant = i;
  endtask

  task automatic idle(input int n);
    s_valid = '0; s_lock = '0;
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      iss_t e;
      rsp_t r;
      if (ram_addr_vld) begin
        if (iss_q.size() == 0) begin
          chk("unexpected issue", 1'b0, 64'(ram_addr), 64'(0));
        end else begin
          e = iss_q.pop_front();
          chk("issue", e.cyc == cyc && ram_wr_en === e.we && ram_addr === e.addr && ram_din === e.din,
              {19'(0), ram_wr_en, ram_addr, ram_din}, {19'(0), e.we, e.addr, e.din});
        end
      end else begin
        chk("idle wr_en", ram_wr_en === 1'b0, 64'(ram_wr_en), 64'(0));
        if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
          e = iss_q.pop_front();
          chk("missing issue", 1'b0, 64'(0), 64'(e.addr));
        end
      end
      if (bus.rsp_valid !== '0) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected rsp", 1'b0, 64'(bus.rsp_valid), 64'(0));
        end else begin
          r = rsp_q.pop_front();
          chk("rsp", r.cyc == cyc && bus.rsp_valid === N'(1 << r.tag) && bus.rsp_data === r.data,
              {28'(0), bus.rsp_valid, bus.rsp_data}, {28'(0), N'(1 << r.tag), r.data});
        end
      end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
        r = rsp_q.pop_front();
        chk("missing rsp", 1'b0, 64'(0), 64'(r.tag));
      end
      chk("err flag", err === exp_err, 64'(err), 64'(exp_err));
    end
  end

  task automatic chk_seq(input string name, input int got[$], input int want[$]);
    for (int i = 0; i < want.size(); i++)
      chk(name, i < got.size() && got[i] == want[i], 64'(i < got.size() ? got[i] : 99), 64'(want[i]));
  endtask

  initial begin
    int gs[$];
    for (int i = 0; i < (1<<AW); i++) refmem[i] = '0;
    for (int i = 0; i < N; i++) begin s_addr[i] = '0; s_wdata[i] = '0; end
    bus.req_valid = '0; bus.req_we = '0; bus.req_lock = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {ram_wr_en, ram_addr_vld, ram_addr, ram_din, bus.rsp_valid, err} === '0,
        64'({ram_wr_en, ram_addr_vld, ram_addr, ram_din, bus.rsp_valid, err}), 64'(0));
    #2 rst_n = 1'b1;
    idle(2);

    // All requesters valid, no lock: strict rotation.
    gs.delete();
    s_valid = '1; s_we = '0; s_lock = '0;
    for (int i = 0; i < N; i++) s_addr[i] = AW'(i);
    repeat (8) begin step(); gs.push_back(last_grant); end
    chk_seq("rotation", gs, '{0, 1, 2, 3, 0, 1, 2, 3});

    // Requester 2 writes two words then reads them back-to-back.
    s_valid = 4'b0100; s_we = 4'b0100;
    s_addr[2] = 12'h010; s_wdata[2] = 32'hA5A5_0001; step();
    s_addr[2] = 12'h011; s_wdata[2] = 32'hA5A5_0002; step();
    idle(1);
    s_valid = 4'b0100; s_we = '0;
    s_addr[2] = 12'h010; step();
    s_addr[2] = 12'h011; step();
    idle(3);

    // Point rotation at 1, then requester 1 locks against everyone.
    s_valid = 4'b0001; step();
    gs.delete();
    s_valid = '1; s_lock = 4'b0010;
    repeat (5) begin step(); gs.push_back(last_grant); end
    // Owner 3 holds two beats then drops valid.
    s_lock = 4'b1000;
    repeat (2) begin step(); gs.push_back(last_grant); end
    s_valid = 4'b0111; step(); gs.push_back(last_grant);
    s_lock = '0; step(); gs.push_back(last_grant);
    chk_seq("lock/drop", gs, '{1, 1, 1, 1, 2, 3, 3, -1, 0});
    idle(3);

    // Randomized traffic.
    repeat (400) begin
      s_valid = N'($urandom);
      s_we    = N'($urandom);
      s_lock  = N'($urandom & $urandom);
      for (int i = 0; i < N; i++) begin
        s_addr[i]  = AW'($urandom_range(0, 15));
        s_wdata[i] = $urandom;
      end
      step();
    end
    idle(3);

    // Reset the cycle after a read accept; then fake a stale RAM valid.
    s_valid = 4'b0001; s_we = '0; s_lock = '0; s_addr[0] = 12'h010; step();
    idle(1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset", {ram_wr_en, ram_addr_vld, ram_addr, ram_din, bus.rsp_valid, err} === '0,
        64'({ram_wr_en, ram_addr_vld, ram_addr, ram_din, bus.rsp_valid, err}), 64'(0));
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1; force_vld = 1'b1;
    @(posedge clk); @(posedge clk); #1 force_vld = 1'b0;
    idle(4);

    // Spurious RAM valid with no read pending sets a sticky error.
    force_vld = 1'b1;
    @(posedge clk); #1 force_vld = 1'b0; exp_err = 1'b1;
    idle(4);
    chk("err sticky", err === 1'b1, 64'(err), 64'(1));
    #1 rst_n = 1'b0;
    #1 chk("err reset", err === 1'b0, 64'(err), 64'(1'b0));
    exp_err = 1'b0;
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    idle(4);

    chk("queues drained", iss_q.size() == 0 && rsp_q.size() == 0,
        64'(iss_q.size() + rsp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
